// File: rtl/bram_line_buffer_nx.sv
// Multi-line BRAM buffer: keeps the last N_LINES video lines in rotating banks and
// emits a vertical column of N_LINES+1 taps per accepted pixel, masking unfilled lines.
module bram_line_buffer_nx #(
  parameter  int DATA_W    = 12,
  parameter  int ADDR_BITS = 11,
  parameter  int N_LINES   = 4,
  localparam int FILL_W    = $clog2(N_LINES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [(N_LINES+1)*DATA_W-1:0] m_taps,
  output logic                          m_last,
  output logic [ADDR_BITS-1:0]          m_col,
  output logic [FILL_W-1:0]             m_fill,
  output logic                          err_ovf
);

  localparam int BANK_W = $clog2(N_LINES);
  localparam int IDX_W  = BANK_W + 1;

  logic [ADDR_BITS-1:0] r_col;
  logic [BANK_W-1:0]    r_wr_bank;
  logic [FILL_W-1:0]    r_fill;
  logic                 r_err;
  logic                 r_m_valid;
  logic                 r_m_last;
  logic [ADDR_BITS-1:0] r_m_col;
  logic [FILL_W-1:0]    r_m_fill;
  logic [BANK_W-1:0]    r_b;
  logic [DATA_W-1:0]    r_tap0;
  logic [DATA_W-1:0]    w_rd [N_LINES];
  logic                 w_accept;
  logic                 w_take;

  assign s_ready  = m_ready || !r_m_valid;
  assign w_accept = s_valid && s_ready;
  assign w_take   = w_accept && !clr;

  genvar gi;
  // One read-first bank per stored line; the read register only moves on a real accept,
  // so a stalled output keeps its read data.
  for (gi = 0; gi < N_LINES; gi++) begin : g_bank
    logic [DATA_W-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_W-1:0] r_rd_data;
    always_ff @(posedge clk) begin
      if (w_take) begin
        r_rd_data <= r_mem[r_col];
        if (r_wr_bank == BANK_W'(gi)) begin
          r_mem[r_col] <= s_data;
        end
      end
    end
    assign w_rd[gi] = r_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_wr_bank <= '0;
      r_fill    <= '0;
      r_err     <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_col   <= '0;
      r_m_fill  <= '0;
      r_b       <= '0;
      r_tap0    <= '0;
    end else if (clr) begin
      r_col     <= '0;
      r_wr_bank <= '0;
      r_fill    <= '0;
      r_err     <= 1'b0;
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_last  <= s_last;
      r_m_col   <= r_col;
      r_m_fill  <= r_fill;
      r_b       <= r_wr_bank;
      r_tap0    <= s_data;
      if (s_last) begin
        r_col     <= '0;
        r_wr_bank <= (r_wr_bank == BANK_W'(N_LINES - 1)) ? '0 : r_wr_bank + 1'b1;
        if (r_fill != FILL_W'(N_LINES)) begin
          r_fill <= r_fill + 1'b1;
        end
      end else begin
        // Overlong line: column wraps and the line carries on, only the flag records it.
        r_col <= r_col + 1'b1;
        if (&r_col) begin
          r_err <= 1'b1;
        end
      end
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_col   = r_m_col;
  assign m_fill  = r_m_fill;
  assign err_ovf = r_err;
  assign m_taps[0 +: DATA_W] = r_tap0;

  // Tap k comes from the bank written k lines ago: (b - k) mod N_LINES, which is b itself for k = N_LINES.
  for (gi = 1; gi <= N_LINES; gi++) begin : g_tap
    localparam logic [IDX_W-1:0]  K_IDX  = IDX_W'(gi);
    localparam logic [IDX_W-1:0]  N_IDX  = IDX_W'(N_LINES);
    localparam logic [FILL_W-1:0] K_FILL = FILL_W'(gi);
    logic [IDX_W-1:0] w_sum;
    logic [IDX_W-1:0] w_idx;
    assign w_sum = {1'b0, r_b} + N_IDX - K_IDX;
    assign w_idx = (w_sum >= N_IDX) ? w_sum - N_IDX : w_sum;
    assign m_taps[gi*DATA_W +: DATA_W] = (K_FILL > r_m_fill) ? '0 : w_rd[w_idx[BANK_W-1:0]];
  end

endmodule

// File: tb/tb_bram_line_buffer_nx.sv
// Randomised and directed bench for bram_line_buffer_nx, checked every cycle against a
// line-history model of the buffer's output column.
module tb_bram_line_buffer_nx;
  localparam int DW   = 12;
  localparam int AB   = 4;
  localparam int NL   = 4;
  localparam int FW   = $clog2(NL + 1);
  localparam int NT   = NL + 1;
  localparam int MAXC = 1 << AB;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [NT*DW-1:0]  m_taps;
  logic              m_last;
  logic [AB-1:0]     m_col;
  logic [FW-1:0]     m_fill;
  logic              err_ovf;

  bram_line_buffer_nx #(.DATA_W(DW), .ADDR_BITS(AB), .N_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_taps(m_taps), .m_last(m_last),
    .m_col(m_col), .m_fill(m_fill), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Line history: the pixel last written to each column of each of the NL line slots.
  logic [DW-1:0] hist  [NL][MAXC];
  bit            known [NL][MAXC];
  int            mcol, mslot, mfill;
  bit            merr;
  // Expected content of the single output stage.
  bit               ev;
  logic [NT*DW-1:0] etaps, ecare;
  int               ecol, efill;
  bit               elast;

  bit logging;
  int consumed[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_m(input string name, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] care);
    n_checks++;
    if ((act & care) !== (exp & care)) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ev = 0; mcol = 0; mslot = 0; mfill = 0; merr = 0;
  endtask

  // Decide from the spec rules what the coming clock edge does, given the inputs now applied.
  task automatic model_step(output bit acc);
    bit rdy;
    int slot;
    rdy = !ev || m_ready;
    chk("s_ready", 64'(s_ready), 64'(rdy));
    acc = s_valid && rdy && !clr;
    if (clr) begin
      model_reset();
    end else if (acc) begin
      etaps = '0;
      ecare = '1;
      etaps[0 +: DW] = s_data;
      for (int k = 1; k <= NL; k++) begin
        slot = (mslot - k + NL) % NL;
        if (k <= mfill) begin
          etaps[k*DW +: DW] = hist[slot][mcol];
          if (!known[slot][mcol]) ecare[k*DW +: DW] = '0;
        end
      end
      ecol = mcol; efill = mfill; elast = s_last; ev = 1;
      hist[mslot][mcol]  = s_data;
      known[mslot][mcol] = 1;
      if (s_last) begin
        mcol = 0;
        mslot = (mslot + 1) % NL;
        if (mfill < NL) mfill++;
      end else if (mcol == MAXC - 1) begin
        mcol = 0;
        merr = 1;
      end else begin
        mcol++;
      end
    end else if (m_ready) begin
      ev = 0;
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("err_ovf", 64'(err_ovf), 64'(merr));
    if (ev) begin
      chk_m("m_taps", 64'(m_taps), 64'(etaps), 64'(ecare));
      chk("m_col", 64'(m_col), 64'(ecol));
      chk("m_fill", 64'(m_fill), 64'(efill));
      chk("m_last", 64'(m_last), 64'(elast));
    end
  endtask

  // One clock: called at a negedge, applies inputs, predicts, then checks at the next negedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit r, input bit c,
                     output bit acc);
    s_valid = v; s_data = d; s_last = l; m_ready = r; clr = c;
    #1;
    if (logging && m_valid && m_ready) consumed.push_back(int'(m_col));
    model_step(acc);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input bit l);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 50) begin
      cyc(1'b1, d, l, 1'b1, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      n_checks++; n_err++;
      $display("FAIL send_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  task automatic do_clr();
    bit acc;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
  endtask

  task automatic drain();
    bit acc;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic check_consumed(input string name, input int exp_q[$]);
    chk({name, "_len"}, 64'(consumed.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < consumed.size(); i++)
      chk(name, 64'(consumed[i]), 64'(exp_q[i]));
    consumed.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int exp_q[$];
    int npix, len, tries;
    logic [NT*DW-1:0] lit;

    rst_n = 0; clr = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 0;
    logging = 0;
    for (int s = 0; s < NL; s++)
      for (int c = 0; c < MAXC; c++) begin hist[s][c] = '0; known[s][c] = 0; end
    model_reset();
    etaps = '0; ecare = '0; ecol = 0; efill = 0; elast = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_taps", 64'(m_taps), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_col", 64'(m_col), 64'd0);
    chk("rst_m_fill", 64'(m_fill), 64'd0);
    chk("rst_err_ovf", 64'(err_ovf), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    rst_n = 1;

    // Fill and ramp, with the masking case on line 1.
    do_clr();
    for (int l = 0; l < 6; l++)
      for (int c = 0; c < 8; c++) begin
        send_pixel(DW'(l * 16 + c), c == 7);
        if (l == 1 && c == 2) begin
          lit = (60'h002 << 12) | 60'h012;
          chk("mask_model_pin", 64'(etaps), 64'(lit));
          chk("mask_taps", 64'(m_taps), 64'(lit));
          chk("mask_fill", 64'(m_fill), 64'd1);
        end
        if (l == 5 && c == 3) begin
          lit = (60'h013 << 48) | (60'h023 << 36) | (60'h033 << 24) | (60'h043 << 12) | 60'h053;
          chk("ramp_model_pin", 64'(etaps), 64'(lit));
          chk("ramp_taps", 64'(m_taps), 64'(lit));
          chk("ramp_fill", 64'(m_fill), 64'd4);
          chk("ramp_latency_valid", 64'(m_valid), 64'd1);
        end
      end
    drain();

    // Backpressure mid-line.
    do_clr();
    logging = 1;
    for (int c = 0; c < 4; c++) send_pixel(DW'(c + 12'h100), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 12'h104, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_no_accept", 64'(acc), 64'd0);
      chk("bp_held_col", 64'(m_col), 64'd3);
    end
    for (int c = 4; c < 8; c++) send_pixel(DW'(c + 12'h100), c == 7);
    drain();
    logging = 0;
    exp_q.delete();
    for (int c = 0; c < 8; c++) exp_q.push_back(c);
    check_consumed("bp_col_seq", exp_q);

    // Overflow: MAXC+1 pixels without s_last.
    do_clr();
    logging = 1;
    for (int c = 0; c <= MAXC; c++) begin
      send_pixel(DW'(c + 12'h200), 1'b0);
      chk("ovf_flag", 64'(err_ovf), (c >= MAXC - 1) ? 64'd1 : 64'd0);
      chk("ovf_fill", 64'(m_fill), 64'd0);
    end
    send_pixel(12'h2FF, 1'b1);
    drain();
    logging = 0;
    exp_q.delete();
    for (int c = 0; c < MAXC; c++) exp_q.push_back(c);
    exp_q.push_back(0);
    exp_q.push_back(1);
    check_consumed("ovf_col_seq", exp_q);

    // A full-length line whose last column carries s_last does not flag overflow.
    do_clr();
    for (int c = 0; c < MAXC; c++) send_pixel(DW'(c), c == MAXC - 1);
    chk("last_at_max_no_ovf", 64'(err_ovf), 64'd0);
    drain();

    // clr during column 4 of line 2.
    do_clr();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 8; c++) send_pixel(DW'(l * 16 + c), c == 7);
    for (int c = 0; c < 4; c++) send_pixel(DW'(32 + c), 1'b0);
    cyc(1'b1, 12'h024, 1'b0, 1'b1, 1'b1, acc);
    chk("clr_drops", 64'(m_valid), 64'd0);
    send_pixel(12'h0AA, 1'b0);
    chk("clr_col", 64'(m_col), 64'd0);
    chk("clr_fill", 64'(m_fill), 64'd0);
    chk("clr_err", 64'(err_ovf), 64'd0);

    // Async reset while the output holds a valid column.
    send_pixel(12'h0AB, 1'b0);
    chk("arst_pre_valid", 64'(m_valid), 64'd1);
    s_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_taps", 64'(m_taps), 64'd0);
    chk("arst_col", 64'(m_col), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    send_pixel(12'h0AC, 1'b0);
    chk("arst_first_col", 64'(m_col), 64'd0);
    chk("arst_first_fill", 64'(m_fill), 64'd0);
    send_pixel(12'h0AD, 1'b1);
    drain();

    // Random stress.
    do_clr();
    npix = 0;
    while (npix < 10000) begin
      len = $urandom_range(1, 16);
      for (int c = 0; c < len; c++) begin
        acc = 0;
        tries = 0;
        while (!acc && tries < 200) begin
          cyc(1'($urandom % 2), DW'($urandom), c == len - 1, 1'($urandom % 2), 1'b0, acc);
          tries++;
        end
        if (!acc) begin
          n_checks++; n_err++;
          $display("FAIL rand_timeout: got no accept expected accept at %0t", $time);
        end
        npix++;
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bram_line_buffer_nx.md
Name: bram_line_buffer_nx

Overview:
- Parametrised multi-line buffer for the demosaicing pipeline. It follows on from the single dual-port 12-bit BRAM and adds configurable pixel width, line depth and line count.
- Stores the last N_LINES video lines in rotating BRAM banks.
- Each accepted pixel produces a vertical column of N_LINES+1 taps: the current pixel plus the same column from each of the N_LINES previous lines.
- Sits between the Bayer input stream and the window/interpolation stage. It has a valid/ready handshake and masks lines that have not yet been filled.

Parameters:
- DATA_W, 12, pixel width in bits.
- ADDR_BITS, 11, column address width; maximum line length is 2**ADDR_BITS pixels.
- N_LINES, 4, number of stored lines (2..8); the block outputs N_LINES+1 taps.

Ports:
- clk  in  1  single clock for all logic and BRAM banks.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of pointers, fill count and error flag (frame start).
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  DATA_W  input pixel.
- s_last  in  1  marks the last pixel of a line.
- m_valid  out  1  output column valid.
- m_ready  in  1  downstream ready.
- m_taps  out  (N_LINES+1)*DATA_W  tap k is at bits [k*DATA_W +: DATA_W]; k=0 is the current pixel, k=N_LINES is the oldest line.
- m_last  out  1  s_last delayed alongside its column.
- m_col  out  ADDR_BITS  column index of the output column.
- m_fill  out  clog2(N_LINES+1)  number of valid previous lines for this column.
- err_ovf  out  1  sticky; set when a line exceeds 2**ADDR_BITS pixels.

Behaviour:
- Reset (rst_n=0, async):
  - Outputs: m_valid=0, m_taps=0, m_last=0, m_col=0, m_fill=0, err_ovf=0.
  - Internal: col=0, wr_bank=0, fill=0.
  - s_ready is 1 once out of reset.
  - BRAM contents are not cleared; unfilled lines are masked instead.
- Handshake:
  - s_ready = m_ready || !m_valid, so there is a single output stage.
  - accept = s_valid && s_ready.
  - When the output is stalled (m_valid && !m_ready), all output registers and the BRAM read data hold their values.
- Storage:
  - N_LINES single-clock BRAM banks, each 2**ADDR_BITS x DATA_W.
  - Banks are read-first: read data is the contents before any write in the same cycle.
- On accept:
  - All banks are read at address col.
  - s_data is written to bank wr_bank at address col.
- Latency: exactly 1 cycle from accept to m_valid=1 carrying that pixel's column. There are no bubbles under continuous valid and ready.
- Tap mapping, registered with the read. Let b = wr_bank captured at accept.
  - tap0 = the accepted s_data.
  - tap N_LINES = read data from bank b. This is the oldest line, valid because of read-first.
  - tap k for 1 <= k <= N_LINES-1 = read data from bank (b-k) mod N_LINES.
- Masking:
  - tap k (k >= 1) is forced to 0 when k > fill at accept time.
  - m_fill = fill at accept time.
- Column and line pointers:
  - On accept with !s_last: col increments.
  - On accept with s_last:
    - col resets to 0;
    - wr_bank advances to (wr_bank+1) mod N_LINES;
    - fill increments, saturating at N_LINES.
- Overflow:
  - If col = 2**ADDR_BITS-1 is accepted without s_last, col wraps to 0 and err_ovf is set.
  - The line continues; wr_bank and fill are unchanged.
- clr:
  - Sets col=0, wr_bank=0, fill=0, err_ovf=0 and m_valid=0.
  - clr takes priority over a simultaneous accept; that pixel is dropped.
- Simultaneous s_last and overflow column: the s_last rule applies and err_ovf is not set.
- Reset mid-line: the partial line is discarded; after release, the first accepted pixel is column 0 with fill=0.
- Arithmetic: pointer arithmetic is modulo as stated; no saturation or truncation of data is performed.

Test Plan:
- Fill and ramp: N_LINES=4, line length 8, 6 lines with pixel = line*16+col, continuous valid/ready.
  - Line 5, col 3 -> m_taps = {0x13, 0x23, 0x33, 0x43, 0x53} (tap4..tap0), m_fill=4, latency 1 cycle.
- Masking: lines 0 and 1 only.
  - Line 1, col 2 -> tap0=0x12, tap1=0x02, tap2..tap4=0, m_fill=1.
- Backpressure: m_ready low for 5 cycles mid-line.
  - m_taps holds stable and s_ready=0; no pixel is lost or duplicated (check the m_col sequence 0..7).
- Overflow: ADDR_BITS=3, 10 pixels without s_last.
  - err_ovf rises when col 7 is accepted; m_col sequence is 0..7, 0, 1; fill stays 0.
- clr and async reset mid-line:
  - clr during col 4 of line 2 -> next output has m_col=0, m_fill=0, err_ovf=0.
  - rst_n pulse while m_valid=1 -> m_valid drops to 0 immediately, without waiting for a clock edge.
- Random stress: random s_valid/m_ready at 50%, random line lengths 1..16.
  - Compare against a reference model of the line history; zero mismatches over 10k pixels.
